// File: rtl/nn_mem_pkg.sv
// nn_mem_pkg
// Shared definitions for the NN weight/activation memory (memory_512kb) and
// the engines that read it.
//   ADDR_W / DATA_W / LEN_W : default word-address, data and burst-length widths
//   MEM_WORDS               : number of 32-bit words in the memory
//   ST_*                    : read-streamer FSM state encoding
//   cnt_width()             : width of a counter able to hold 0..depth inclusive
package nn_mem_pkg;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 15;
    localparam int MEM_WORDS = 16384;

    typedef logic [1:0] fsm_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock show-ahead FIFO. The head word is visible on rd_data whenever
// empty is low; rd_en pops it. A push and a pop may share a cycle, including
// when the FIFO is full (the pop frees the slot being written).
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push wr_data (ignored when full without a simultaneous pop)
//   rd_en      : pop the head word (ignored when empty)
//   rd_data    : head word
//   count      : number of stored words, 0..DEPTH
//   full/empty : occupancy flags
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              wr_fire;
    logic              rd_fire;
    logic [DEPTH-1:0]  slot_we;

    assign full    = (count_reg == DEPTH_CNT);
    assign empty   = (count_reg == '0);
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);

    // One write strobe per storage slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = wr_fire && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Storage is reset so the stream data output is zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_we[i]) begin
                    mem_reg[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(wr_fire);
            rd_ptr_reg <= rd_ptr_reg + AW'(rd_fire);
            count_reg  <= count_reg + (AW + 1)'(wr_fire) - (AW + 1)'(rd_fire);
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/mem_read_streamer.sv
// mem_read_streamer
// Burst read engine for memory_512kb. A start command captures base_addr/len,
// then single-word reads are issued (address wraps modulo 2^ADDR_W), returned
// words are buffered in a show-ahead FIFO and presented as a valid/ready
// stream with m_last on the final word. Reads are credit limited so that every
// word in flight always has a FIFO slot waiting for it.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, base_addr, len : command (accepted only when idle)
//   busy, done            : busy from accepted start through the done pulse
//   mem_rd_en, mem_addr   : read request to memory
//   mem_data_in/valid_in  : read response, one cycle after each request
//   m_valid/m_ready/m_data/m_last : output stream
module mem_read_streamer
    import nn_mem_pkg::*;
#(
    parameter int ADDR_W     = nn_mem_pkg::ADDR_W,
    parameter int DATA_W     = nn_mem_pkg::DATA_W,
    parameter int LEN_W      = nn_mem_pkg::LEN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_valid_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    fsm_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  issued_reg;
    logic [LEN_W-1:0]  delivered_reg, delivered_next;
    logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
    logic              mem_rd_en_reg;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              busy_reg;
    logic              done_reg;

    logic [CNT_W-1:0]  fifo_count, fifo_count_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic              rsp_accept;
    logic              push;
    logic              pop;
    logic              issue;
    logic [CNT_W:0]    credit_sum;
    logic              credit_ok;

    // A response only counts if we are actually waiting for one; anything
    // else (e.g. a reply to a read issued before reset) is dropped.
    assign rsp_accept = mem_valid_in && (outstanding_reg != '0);
    assign pop        = m_valid && m_ready;
    assign push       = rsp_accept && (!fifo_full || pop);

    // Credit check looks at the occupancy the next cycle will start with, so
    // a request issued then still has a guaranteed slot when its data lands
    // even if the consumer stops popping.
    assign fifo_count_next  = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign outstanding_next = outstanding_reg + CNT_W'(mem_rd_en_reg) - CNT_W'(rsp_accept);
    assign credit_sum       = {1'b0, fifo_count_next} + {1'b0, outstanding_next};
    assign credit_ok        = (credit_sum < DEPTH_LIMIT);
    assign delivered_next   = delivered_reg + LEN_W'(pop);

    always_comb begin
        state_next    = state_reg;
        issue         = 1'b0;
        mem_addr_next = mem_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        // FIFO is empty in idle, so the first read always has credit.
                        issue         = 1'b1;
                        mem_addr_next = base_addr;
                        state_next    = (len == LEN_W'(1)) ? ST_DRAIN : ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (credit_ok) begin
                    issue         = 1'b1;
                    // Truncation to ADDR_W gives the modulo wrap.
                    mem_addr_next = base_reg + ADDR_W'(issued_reg);
                    if (issued_reg + LEN_W'(1) == len_reg) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (delivered_next == len_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            base_reg        <= '0;
            len_reg         <= '0;
            issued_reg      <= '0;
            delivered_reg   <= '0;
            outstanding_reg <= '0;
            mem_rd_en_reg   <= 1'b0;
            mem_addr_reg    <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            busy_reg        <= (state_next != ST_IDLE);
            done_reg        <= (state_next == ST_DONE);
            mem_rd_en_reg   <= issue;
            mem_addr_reg    <= mem_addr_next;
            outstanding_reg <= outstanding_next;
            if (state_reg == ST_IDLE) begin
                if (start) begin
                    base_reg <= base_addr;
                    len_reg  <= len;
                end
                // issued counts requests already registered onto the bus.
                issued_reg    <= LEN_W'(issue);
                delivered_reg <= '0;
            end else begin
                issued_reg    <= issued_reg + LEN_W'(issue);
                delivered_reg <= delivered_next;
            end
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (mem_data_in),
        .rd_en   (pop),
        .rd_data (m_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_valid   = !fifo_empty;
    assign m_last    = m_valid && (delivered_reg == len_reg - LEN_W'(1));
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign mem_rd_en = mem_rd_en_reg;
    assign mem_addr  = mem_addr_reg;

endmodule

// File: tb/tb_mem_read_streamer.sv
module tb_mem_read_streamer;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in = '0;
    logic              mem_valid_in = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    mem_read_streamer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_valid_in(mem_valid_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int c0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: mem[k] = 0xA5000000 + k, one-cycle read latency.
    logic inject_valid = 1'b0;
    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'hA500_0000 + {18'd0, a};
    endfunction
    always @(posedge clk) begin
        mem_valid_in <= mem_rd_en | inject_valid;
        mem_data_in  <= inject_valid ? 32'hDEAD_BEEF : mem_word(mem_addr);
    end

    // Consumer ready: 0 = always 1, 1 = repeating 1,0,0,1, 2 = always 0.
    int ready_mode = 0;
    int ready_phase = 0;
    initial begin
        logic [3:0] pat;
        pat = 4'b1001;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                m_ready = pat[ready_phase];
                ready_phase = (ready_phase + 1) % 4;
            end else begin
                m_ready = (ready_mode == 0);
            end
        end
    end

    // Monitor
    logic [31:0]       got_data[$];
    logic              got_last[$];
    logic [ADDR_W-1:0] got_addr[$];
    int                done_cycles[$];
    int inflight = 0, max_inflight = 0, valid_seen = 0, stable_err = 0;
    initial begin
        logic prev_valid, prev_ready;
        logic [31:0] prev_data;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_valid && !prev_ready && (!m_valid || m_data !== prev_data)) stable_err++;
                if (mem_rd_en) begin got_addr.push_back(mem_addr); inflight++; end
                if (m_valid) valid_seen++;
                if (m_valid && m_ready) begin
                    got_data.push_back(m_data); got_last.push_back(m_last); inflight--;
                end
                if (done) done_cycles.push_back(cyc - c0);
                if (inflight > max_inflight) max_inflight = inflight;
            end
            prev_valid = m_valid; prev_ready = m_ready; prev_data = m_data;
        end
    end

    task automatic clear_rec();
        got_data.delete(); got_last.delete(); got_addr.delete(); done_cycles.delete();
        inflight = 0; max_inflight = 0; valid_seen = 0; stable_err = 0;
    endtask

    task automatic launch(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        @(negedge clk);
        base_addr = b; len = l; start = 1'b1; c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cycles.size() > 0) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_timeout got=no_done required=done within %0d cycles", name, budget); end
    endtask

    function automatic int first_done();
        return (done_cycles.size() > 0) ? done_cycles[0] : -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, mem_rd_en, m_valid, m_last} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b required=00000", {busy, done, mem_rd_en, m_valid, m_last});
        end
        checks++;
        if (mem_addr !== '0 || m_data !== '0) begin
            failures++; $display("FAIL reset_addr_data got=%0h/%0h required=0/0", mem_addr, m_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, mem_rd_en, m_valid} !== 3'b0) begin
            failures++; $display("FAIL idle_after_reset got=%b required=000", {busy, mem_rd_en, m_valid});
        end
        $display("reset: released, idle outputs sampled");
    endtask

    task automatic test_basic();
        int nlast;
        clear_rec(); ready_mode = 0;
        launch(14'd0, 15'd10);
        wait_done(60, "basic");
        repeat (5) @(negedge clk);
        checks++;
        if (got_data.size() != 10) begin failures++; $display("FAIL basic_count got=%0d required=10", got_data.size()); end
        nlast = 0;
        for (int i = 0; i < got_data.size() && i < 10; i++) begin
            checks++;
            if (got_data[i] !== 32'hA500_0000 + i) begin
                failures++; $display("FAIL basic_data[%0d] got=%h required=%h", i, got_data[i], 32'hA500_0000 + i);
            end
            if (got_last[i]) nlast++;
        end
        checks++;
        if (nlast != 1 || got_last.size() != 10 || got_last[9] !== 1'b1) begin
            failures++; $display("FAIL basic_last got=%0d_last_flags required=1_on_word9", nlast);
        end
        checks++;
        if (first_done() != 13) begin failures++; $display("FAIL basic_done_cycle got=%0d required=13", first_done()); end
        checks++;
        if (done_cycles.size() != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d required=1", done_cycles.size()); end
        for (int i = 0; i < got_addr.size() && i < 10; i++) begin
            checks++;
            if (got_addr[i] !== ADDR_W'(i)) begin failures++; $display("FAIL basic_addr[%0d] got=%0d required=%0d", i, got_addr[i], i); end
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b required=0", busy); end
        $display("burst base=0 len=10 ready=1 words=%0d done_cycle=%0d", got_data.size(), first_done());
    endtask

    task automatic test_backpressure();
        clear_rec(); ready_phase = 0; ready_mode = 1;
        launch(14'd0, 15'd10);
        wait_done(120, "bp");
        repeat (5) @(negedge clk);
        ready_mode = 0;
        checks++;
        if (got_data.size() != 10) begin failures++; $display("FAIL bp_count got=%0d required=10", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 10; i++) begin
            checks++;
            if (got_data[i] !== 32'hA500_0000 + i || got_last[i] !== (i == 9)) begin
                failures++; $display("FAIL bp_data[%0d] got=%h/%b required=%h/%b", i, got_data[i], got_last[i], 32'hA500_0000 + i, (i == 9));
            end
        end
        checks++;
        if (max_inflight > 4) begin failures++; $display("FAIL bp_credit got=max_inflight_%0d required<=4", max_inflight); end
        checks++;
        if (got_addr.size() != 10) begin failures++; $display("FAIL bp_reads got=%0d required=10", got_addr.size()); end
        checks++;
        if (stable_err != 0) begin failures++; $display("FAIL bp_hold_stable got=%0d_changes required=0", stable_err); end
        checks++;
        if (done_cycles.size() != 1 || first_done() <= 13) begin
            failures++; $display("FAIL bp_done got=%0d_pulses_at_%0d required=1_pulse_after_13", done_cycles.size(), first_done());
        end
        $display("burst base=0 len=10 ready=1001 words=%0d done_cycle=%0d max_inflight=%0d", got_data.size(), first_done(), max_inflight);
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_addr [4];
        exp_addr[0] = 14'd16382; exp_addr[1] = 14'd16383; exp_addr[2] = 14'd0; exp_addr[3] = 14'd1;
        clear_rec(); ready_mode = 0;
        launch(14'd16382, 15'd4);
        wait_done(40, "wrap");
        repeat (3) @(negedge clk);
        checks++;
        if (got_addr.size() != 4 || got_data.size() != 4) begin
            failures++; $display("FAIL wrap_count got=%0d/%0d required=4/4", got_addr.size(), got_data.size());
        end
        for (int i = 0; i < 4 && i < got_addr.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== mem_word(exp_addr[i])) begin
                failures++; $display("FAIL wrap[%0d] got=%0d/%h required=%0d/%h", i, got_addr[i], got_data[i], exp_addr[i], mem_word(exp_addr[i]));
            end
        end
        checks++;
        if (first_done() != 7) begin failures++; $display("FAIL wrap_done_cycle got=%0d required=7", first_done()); end
        $display("burst base=16382 len=4 ready=1 words=%0d done_cycle=%0d", got_data.size(), first_done());
    endtask

    task automatic test_len0();
        clear_rec(); ready_mode = 0;
        launch(14'd5, 15'd0);
        #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL len0_cycle1 got=busy%b_done%b required=busy1_done1", busy, done); end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL len0_cycle2 got=busy%b_done%b required=busy0_done0", busy, done); end
        repeat (5) @(negedge clk);
        checks++;
        if (got_addr.size() != 0 || valid_seen != 0) begin
            failures++; $display("FAIL len0_activity got=%0d_reads_%0d_valid required=0_0", got_addr.size(), valid_seen);
        end
        checks++;
        if (done_cycles.size() != 1 || first_done() != 1) begin
            failures++; $display("FAIL len0_done got=%0d_pulses_at_%0d required=1_at_1", done_cycles.size(), first_done());
        end
        $display("burst base=5 len=0 words=0 done_cycle=%0d", first_done());
    endtask

    task automatic test_ignore_start();
        clear_rec(); ready_mode = 0;
        launch(14'd0, 15'd10);
        repeat (2) @(negedge clk);
        base_addr = 14'd100; len = 15'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(60, "ignore");
        repeat (30) @(negedge clk);
        checks++;
        if (done_cycles.size() != 1 || first_done() != 13) begin
            failures++; $display("FAIL ignore_done got=%0d_pulses_at_%0d required=1_at_13", done_cycles.size(), first_done());
        end
        checks++;
        if (got_data.size() != 10 || got_addr.size() != 10) begin
            failures++; $display("FAIL ignore_count got=%0d/%0d required=10/10", got_data.size(), got_addr.size());
        end
        for (int i = 0; i < got_data.size() && i < 10; i++) begin
            checks++;
            if (got_data[i] !== 32'hA500_0000 + i) begin
                failures++; $display("FAIL ignore_data[%0d] got=%h required=%h", i, got_data[i], 32'hA500_0000 + i);
            end
        end
        $display("burst base=0 len=10 second_start=ignored words=%0d done_cycle=%0d", got_data.size(), first_done());
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_rec(); ready_mode = 2;
        launch(14'd0, 15'd10);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (got_addr.size() >= 3) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_reads got=%0d required=3", got_addr.size()); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_rd_en, m_valid, m_last} !== 5'b0 || mem_addr !== '0 || m_data !== '0) begin
            failures++; $display("FAIL rstmid_async got=%b/%0h/%h required=00000/0/0", {busy, done, mem_rd_en, m_valid, m_last}, mem_addr, m_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_rec(); ready_mode = 0;
        inject_valid = 1'b1;
        @(negedge clk);
        inject_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (valid_seen != 0) begin failures++; $display("FAIL rstmid_late_rsp got=%0d_valid_cycles required=0", valid_seen); end
        clear_rec();
        launch(14'd20, 15'd2);
        wait_done(40, "rstmid");
        repeat (5) @(negedge clk);
        checks++;
        if (got_data.size() != 2) begin
            failures++; $display("FAIL rstmid_count got=%0d required=2", got_data.size());
        end else begin
            checks++;
            if (got_data[0] !== 32'hA500_0014 || got_data[1] !== 32'hA500_0015 || got_last[1] !== 1'b1 || got_last[0] !== 1'b0) begin
                failures++; $display("FAIL rstmid_data got=%h,%h required=a5000014,a5000015", got_data[0], got_data[1]);
            end
        end
        checks++;
        if (first_done() != 5) begin failures++; $display("FAIL rstmid_done_cycle got=%0d required=5", first_done()); end
        $display("burst base=20 len=2 after_reset words=%0d done_cycle=%0d", got_data.size(), first_done());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_len0();
        test_ignore_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
